can_rx: RTL and testbench

- Serial receiver for the team's simplified CAN-style frame, one bit per clk, bus sampled on every rising edge.
- Frame format: SOF(0), 11-bit address MSB first, RTR/IDE/reserved (all recessive 1), 4-bit DLC MSB first, DLC data bytes MSB first, ACK slot, ACK delimiter, EOF.
- Deframes incoming traffic, drives the dominant ACK and presents each complete frame as a one-cycle-valid parallel record.
- Sits at the bus side, opposite the frame transmitter.

---
 rtl/can_rx_pkg.sv | 34 +++
 rtl/can_rx_if.sv | 39 +++
 rtl/can_rx_shift.sv | 37 +++
 rtl/can_rx.sv | 230 +++++++++++++++++++++++
 tb/tb_can_rx.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/can_rx_pkg.sv
// Shared CAN frame definitions: receiver FSM states, field widths, bus levels
// and default frame-timing constants. The frame transmitter imports this package too.
package can_pkg;

   localparam int ADDR_W = 11;
   localparam int DLC_W  = 4;

   localparam logic DOMINANT  = 1'b0;
   localparam logic RECESSIVE = 1'b1;

   localparam int MAX_BYTES_DEF    = 8;
   localparam int EOF_BITS_DEF     = 7;
   localparam int RECOVER_BITS_DEF = 7;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_RTR,
      ST_IDE,
      ST_RSV,
      ST_DLC,
      ST_DATA,
      ST_ACK,
      ST_ACK_DEL,
      ST_EOF,
      ST_ERROR
   } can_state_e;

   // Number of payload bytes actually carried for a given DLC.
   function automatic int clamp_bytes(input int dlc, input int max_bytes);
      return (dlc > max_bytes) ? max_bytes : dlc;
   endfunction

endpackage

// File: rtl/can_rx_if.sv
// Bus-side and record-side signals of the CAN receiver.
// Optional macro CAN_RX_ADDR_FILTER_EN adds the acceptance id/mask inputs.
interface can_rx_if #(
   parameter int MAX_BYTES = 8
);
   import can_pkg::*;

   logic                   rx;
   logic                   tx_ack;
   logic                   rx_busy;
   logic                   frame_valid;
   logic                   frame_error;
   logic [ADDR_W-1:0]      rx_address;
   logic [DLC_W-1:0]       rx_dlc;
   logic [8*MAX_BYTES-1:0] rx_data;
`ifdef CAN_RX_ADDR_FILTER_EN
   logic [ADDR_W-1:0]      acc_id;
   logic [ADDR_W-1:0]      acc_mask;

   modport slave (
      input  rx, acc_id, acc_mask,
      output tx_ack, rx_busy, frame_valid, frame_error, rx_address, rx_dlc, rx_data
   );
   modport master (
      output rx, acc_id, acc_mask,
      input  tx_ack, rx_busy, frame_valid, frame_error, rx_address, rx_dlc, rx_data
   );
`else
   modport slave (
      input  rx,
      output tx_ack, rx_busy, frame_valid, frame_error, rx_address, rx_dlc, rx_data
   );
   modport master (
      output rx,
      input  tx_ack, rx_busy, frame_valid, frame_error, rx_address, rx_dlc, rx_data
   );
`endif

endinterface

// File: rtl/can_rx_shift.sv
// Serial-to-parallel shifter split into lanes; only the selected lane shifts,
// so bytes land in their own slot without moving earlier bytes.
module can_rx_shift #(
   parameter int NLANES = 1,
   parameter int LANE_W = 8,
   parameter int SEL_W  = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr_i,
   input  logic                     shift_en_i,
   input  logic                     bit_i,
   input  logic [SEL_W-1:0]         lane_sel_i,
   output logic [NLANES*LANE_W-1:0] data_o
);

   genvar gi;
   generate
      for (gi = 0; gi < NLANES; gi++) begin : g_lane
         logic [LANE_W-1:0] lane_q;

         // Clear the lane at frame start, shift MSB-first while selected.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               lane_q <= '0;
            end else if (clr_i) begin
               lane_q <= '0;
            end else if (shift_en_i && (lane_sel_i == SEL_W'(gi))) begin
               lane_q <= {lane_q[LANE_W-2:0], bit_i};
            end
         end

         assign data_o[gi*LANE_W +: LANE_W] = lane_q;
      end
   endgenerate

endmodule

// File: rtl/can_rx.sv
// CAN-style frame receiver: deframes the serial bus, drives the ACK slot and
// publishes each clean frame as a one-cycle-valid record.
// Optional macro CAN_RX_ADDR_FILTER_EN enables acceptance filtering on the address.
module can_rx
   import can_pkg::*;
#(
   parameter int MAX_BYTES    = MAX_BYTES_DEF,
   parameter int EOF_BITS     = EOF_BITS_DEF,
   parameter int RECOVER_BITS = RECOVER_BITS_DEF
) (
   input  logic    clk,
   input  logic    rst,
   can_rx_if.slave bus
);

   localparam int BYTE_W = $clog2(MAX_BYTES + 1);
   localparam int DSEL_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
   localparam int DATA_W = 8 * MAX_BYTES;

   can_state_e        state_q, state_d;
   logic [3:0]        addr_cnt_q, addr_cnt_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [BYTE_W-1:0] nbytes_q, nbytes_d;
   logic [2:0]        eof_cnt_q, eof_cnt_d;
   logic [2:0]        rec_cnt_q, rec_cnt_d;
   logic [DLC_W-1:0]  dlc_q, dlc_d;
   logic [DLC_W-1:0]  dlc_full;

   logic              eof_done;
   logic              shadow_clr;
   logic              addr_shift_en;
   logic              data_shift_en;
   logic              addr_match;

   logic [ADDR_W-1:0] addr_shadow;
   logic [DATA_W-1:0] data_shadow;

   logic              tx_ack_q;
   logic              frame_valid_q;
   logic              frame_error_q;
   logic [ADDR_W-1:0] rx_address_q;
   logic [DLC_W-1:0]  rx_dlc_q;
   logic [DATA_W-1:0] rx_data_q;

   // DLC value including the bit being sampled this cycle
   assign dlc_full = {dlc_q[DLC_W-2:0], bus.rx};

   can_rx_shift #(
      .NLANES (1),
      .LANE_W (ADDR_W),
      .SEL_W  (1)
   ) u_addr_shift (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (shadow_clr),
      .shift_en_i (addr_shift_en),
      .bit_i      (bus.rx),
      .lane_sel_i (1'b0),
      .data_o     (addr_shadow)
   );

   can_rx_shift #(
      .NLANES (MAX_BYTES),
      .LANE_W (8),
      .SEL_W  (DSEL_W)
   ) u_data_shift (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (shadow_clr),
      .shift_en_i (data_shift_en),
      .bit_i      (bus.rx),
      .lane_sel_i (byte_cnt_q[DSEL_W-1:0]),
      .data_o     (data_shadow)
   );

`ifdef CAN_RX_ADDR_FILTER_EN
   logic match_q;

   // Latch the acceptance decision as the last address bit arrives.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         match_q <= 1'b0;
      end else if ((state_q == ST_ADDR) && (addr_cnt_q == 4'd10)) begin
         match_q <= ((({addr_shadow[ADDR_W-2:0], bus.rx} ^ bus.acc_id) & bus.acc_mask) == '0);
      end
   end

   assign addr_match = match_q;
`else
   assign addr_match = 1'b1;
`endif

   // State and counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         addr_cnt_q <= '0;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         nbytes_q   <= '0;
         eof_cnt_q  <= '0;
         rec_cnt_q  <= '0;
         dlc_q      <= '0;
      end else begin
         state_q    <= state_d;
         addr_cnt_q <= addr_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         nbytes_q   <= nbytes_d;
         eof_cnt_q  <= eof_cnt_d;
         rec_cnt_q  <= rec_cnt_d;
         dlc_q      <= dlc_d;
      end
   end

   // Next-state logic: walk the frame fields, bail to ERROR on any bad fixed bit.
   always_comb begin
      state_d       = state_q;
      addr_cnt_d    = addr_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      byte_cnt_d    = byte_cnt_q;
      nbytes_d      = nbytes_q;
      eof_cnt_d     = eof_cnt_q;
      rec_cnt_d     = '0;
      dlc_d         = dlc_q;
      eof_done      = 1'b0;
      shadow_clr    = 1'b0;
      addr_shift_en = 1'b0;
      data_shift_en = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.rx == DOMINANT) begin
               state_d    = ST_ADDR;
               addr_cnt_d = '0;
               shadow_clr = 1'b1;
            end
         end
         ST_ADDR: begin
            addr_shift_en = 1'b1;
            addr_cnt_d    = addr_cnt_q + 4'd1;
            if (addr_cnt_q == 4'd10) begin
               state_d = ST_RTR;
            end
         end
         ST_RTR: state_d = (bus.rx == RECESSIVE) ? ST_IDE : ST_ERROR;
         ST_IDE: state_d = (bus.rx == RECESSIVE) ? ST_RSV : ST_ERROR;
         ST_RSV: begin
            state_d   = (bus.rx == RECESSIVE) ? ST_DLC : ST_ERROR;
            bit_cnt_d = '0;
         end
         ST_DLC: begin
            dlc_d     = dlc_full;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd3) begin
               nbytes_d   = BYTE_W'(clamp_bytes(int'(dlc_full), MAX_BYTES));
               bit_cnt_d  = '0;
               byte_cnt_d = '0;
               state_d    = (nbytes_d == '0) ? ST_ACK : ST_DATA;
            end
         end
         ST_DATA: begin
            data_shift_en = 1'b1;
            bit_cnt_d     = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               byte_cnt_d = byte_cnt_q + BYTE_W'(1);
               if (byte_cnt_q == nbytes_q - BYTE_W'(1)) begin
                  state_d = ST_ACK;
               end
            end
         end
         ST_ACK: state_d = ST_ACK_DEL;
         ST_ACK_DEL: begin
            state_d   = (bus.rx == RECESSIVE) ? ST_EOF : ST_ERROR;
            eof_cnt_d = '0;
         end
         ST_EOF: begin
            if (bus.rx != RECESSIVE) begin
               state_d = ST_ERROR;
            end else if (eof_cnt_q == 3'(EOF_BITS - 1)) begin
               state_d  = ST_IDLE;
               eof_done = 1'b1;
            end else begin
               eof_cnt_d = eof_cnt_q + 3'd1;
            end
         end
         ST_ERROR: begin
            if (bus.rx == RECESSIVE) begin
               if (rec_cnt_q == 3'(RECOVER_BITS - 1)) begin
                  state_d = ST_IDLE;
               end else begin
                  rec_cnt_d = rec_cnt_q + 3'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ACK drive, status pulses and the published frame record.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_ack_q      <= RECESSIVE;
         frame_valid_q <= 1'b0;
         frame_error_q <= 1'b0;
         rx_address_q  <= '0;
         rx_dlc_q      <= '0;
         rx_data_q     <= '0;
      end else begin
         tx_ack_q      <= ((state_d == ST_ACK) && addr_match) ? DOMINANT : RECESSIVE;
         frame_valid_q <= eof_done && addr_match;
         frame_error_q <= (state_d == ST_ERROR) && (state_q != ST_ERROR);
         if (eof_done && addr_match) begin
            rx_address_q <= addr_shadow;
            rx_dlc_q     <= dlc_q;
            rx_data_q    <= data_shadow;
         end
      end
   end

   assign bus.tx_ack      = tx_ack_q;
   assign bus.rx_busy     = (state_q != ST_IDLE);
   assign bus.frame_valid = frame_valid_q;
   assign bus.frame_error = frame_error_q;
   assign bus.rx_address  = rx_address_q;
   assign bus.rx_dlc      = rx_dlc_q;
   assign bus.rx_data     = rx_data_q;

endmodule

// File: tb/tb_can_rx.sv
// Scoreboard bench for can_rx: the driver pushes expected ACK, error and
// frame records when it issues a frame; a negedge monitor pops and compares.
module tb_can_rx;
   import can_pkg::*;

   localparam int MAXB = 8;

   typedef struct {
      int          cyc;
      logic [10:0] addr;
      logic [3:0]  dlc;
      logic [63:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   exp_t valid_q[$];
   int   ack_q[$];
   int   err_q[$];
   exp_t last;
   exp_t mon_e;
   logic frm[$];
   int   frm_nb;

   can_rx_if #(.MAX_BYTES(MAXB)) bus ();

   can_rx #(
      .MAX_BYTES    (MAXB),
      .EOF_BITS     (7),
      .RECOVER_BITS (7)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end else begin
         $display("[TB] ok   %s = %h (cycle %0d)", name, act, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      n_tests++;
      n_fail++;
      $display("[TB] FAIL %s: got event at cycle %0d expected none", name, cyc);
   endtask

   // Monitor: every output event must match the head of its queue.
   always @(negedge clk) begin
      if (bus.frame_valid === 1'b1) begin
         if (valid_q.size() == 0) begin
            unexpected("frame_valid");
         end else begin
            mon_e = valid_q.pop_front();
            check("valid_cycle", 64'(cyc), 64'(mon_e.cyc));
            check("rx_address", 64'(bus.rx_address), 64'(mon_e.addr));
            check("rx_dlc", 64'(bus.rx_dlc), 64'(mon_e.dlc));
            check("rx_data", bus.rx_data, mon_e.data);
         end
      end
      if (bus.tx_ack === 1'b0) begin
         if (ack_q.size() == 0) unexpected("tx_ack_low");
         else check("ack_cycle", 64'(cyc), 64'(ack_q.pop_front()));
      end
      if (bus.frame_error === 1'b1) begin
         if (err_q.size() == 0) unexpected("frame_error");
         else check("error_cycle", 64'(cyc), 64'(err_q.pop_front()));
      end
   end

   task automatic build_frame(input logic [10:0] addr, input logic [3:0] dlc, input logic [63:0] data);
      frm.delete();
      frm_nb = (int'(dlc) > MAXB) ? MAXB : int'(dlc);
      frm.push_back(1'b0);
      for (int i = 10; i >= 0; i--) frm.push_back(addr[i]);
      repeat (3) frm.push_back(1'b1);
      for (int i = 3; i >= 0; i--) frm.push_back(dlc[i]);
      for (int k = 0; k < frm_nb; k++)
         for (int i = 7; i >= 0; i--) frm.push_back(data[8*k+i]);
      frm.push_back(1'b1);              // ACK slot (ignored by receiver)
      frm.push_back(1'b1);              // ACK delimiter
      repeat (7) frm.push_back(1'b1);   // EOF
   endtask

   task automatic send_good(input logic [10:0] addr, input logic [3:0] dlc,
                            input logic [63:0] data, input bit deliver);
      exp_t e;
      int   sof;
      build_frame(addr, dlc, data);
      $display("[TB] frame addr=%h dlc=%0d deliver=%0d", addr, dlc, deliver);
      for (int i = 0; i < frm.size(); i++) begin
         @(negedge clk);
         bus.rx = frm[i];
         if (i == 0) begin
            sof = cyc;
            check("busy_at_sof", 64'(bus.rx_busy), 64'd0);
            if (deliver) begin
               ack_q.push_back(sof + 19 + 8*frm_nb);
               e.cyc  = sof + 28 + 8*frm_nb;
               e.addr = addr;
               e.dlc  = dlc;
               e.data = '0;
               for (int k = 0; k < frm_nb; k++) e.data[8*k +: 8] = data[8*k +: 8];
               valid_q.push_back(e);
               last = e;
            end
         end
         if (i == 1) check("busy_in_addr", 64'(bus.rx_busy), 64'd1);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.rx = 1'b1;
      end
   endtask

   initial begin
      bus.rx = 1'b1;
`ifdef CAN_RX_ADDR_FILTER_EN
      bus.acc_id   = 11'h000;
      bus.acc_mask = 11'h000;
`endif
      last = '{cyc: 0, addr: '0, dlc: '0, data: '0};
      repeat (3) @(negedge clk);
      check("rst_tx_ack", 64'(bus.tx_ack), 64'd1);
      check("rst_busy", 64'(bus.rx_busy), 64'd0);
      check("rst_valid", 64'(bus.frame_valid), 64'd0);
      check("rst_error", 64'(bus.frame_error), 64'd0);
      check("rst_address", 64'(bus.rx_address), 64'd0);
      check("rst_dlc", 64'(bus.rx_dlc), 64'd0);
      check("rst_data", bus.rx_data, 64'd0);
      rst = 1'b1;
      idle(2);

      // Two-byte frame followed back-to-back by a zero-length frame
      send_good(11'h5A3, 4'd2, 64'h7EC3, 1'b1);
      send_good(11'h001, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      idle(2);

      // DLC above the byte limit: eight bytes captured, raw DLC reported
      send_good(11'h7FF, 4'd15, 64'h0807_0605_0403_0201, 1'b1);
      idle(2);

      // IDE dominant: error, a 0 during recovery restarts the count
      begin
         int sof;
         build_frame(11'h2AA, 4'd0, 64'd0);
         frm[13] = 1'b0;
         $display("[TB] frame addr=2aa with dominant IDE");
         for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus.rx = frm[i];
            if (i == 0) begin
               sof = cyc;
               err_q.push_back(sof + 14);
            end
         end
         idle(3);
         @(negedge clk);
         bus.rx = 1'b0;
         idle(6);
         @(negedge clk);
         bus.rx = 1'b1;
         check("busy_before_recover", 64'(bus.rx_busy), 64'd1);
         @(negedge clk);
         bus.rx = 1'b1;
         check("recover_cycle", 64'(cyc), 64'(sof + 25));
         check("busy_after_recover", 64'(bus.rx_busy), 64'd0);
         check("hold_address", 64'(bus.rx_address), 64'(last.addr));
         check("hold_dlc", 64'(bus.rx_dlc), 64'(last.dlc));
         check("hold_data", bus.rx_data, last.data);
      end
      send_good(11'h2AA, 4'd1, 64'h5C, 1'b1);
      idle(2);

      // Reset asserted during DATA aborts at once
      build_frame(11'h3C3, 4'd3, 64'h33_2211);
      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         bus.rx = frm[i];
      end
      #2 rst = 1'b0;
      #1;
      check("abort_tx_ack", 64'(bus.tx_ack), 64'd1);
      check("abort_busy", 64'(bus.rx_busy), 64'd0);
      check("abort_valid", 64'(bus.frame_valid), 64'd0);
      check("abort_error", 64'(bus.frame_error), 64'd0);
      check("abort_address", 64'(bus.rx_address), 64'd0);
      check("abort_dlc", 64'(bus.rx_dlc), 64'd0);
      check("abort_data", bus.rx_data, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      bus.rx = 1'b1;
      idle(1);
      send_good(11'h155, 4'd4, 64'hDDCC_BBAA, 1'b1);
      idle(2);

`ifdef CAN_RX_ADDR_FILTER_EN
      bus.acc_id   = 11'h100;
      bus.acc_mask = 11'h700;
      send_good(11'h1FF, 4'd1, 64'hA5, 1'b1);
      send_good(11'h2FF, 4'd1, 64'h5A, 1'b0);
      idle(3);
      check("filter_hold_address", 64'(bus.rx_address), 64'h1FF);
`endif

      idle(5);
      check("pending_valid", 64'(valid_q.size()), 64'd0);
      check("pending_ack", 64'(ack_q.size()), 64'd0);
      check("pending_error", 64'(err_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
